// File: rtl/immediate_encoder.sv
// immediate_encoder: range-checks a 64-bit immediate and scatters it into an instruction template.
module immediate_encoder #(parameter int ERR_CNT_W = 8) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_template,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
`ifdef ENCODER_ERR_COUNT_EN
  output logic [ERR_CNT_W-1:0] err_count,
`endif
  output logic        out_error
);
  localparam logic [2:0] F_I = 3'd0, F_S = 3'd1, F_B = 3'd2, F_J = 3'd3, F_U = 3'd4;
  logic               s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [31:0]        s1_tmpl_q, s1_tmpl_d, s1_imm_q, s1_imm_d;
  logic [2:0]         s1_fmt_q, s1_fmt_d, fmt;
  logic               s1_err_q, s1_err_d;
  logic [31:0]        out_instruction_q, out_instruction_d, word;
  logic               out_error_q, out_error_d;
  logic               legal, s2_load, s1_to_s2, in_hs;
  logic signed [63:0] imm_s;
  assign imm_s = in_imm;
  always_comb begin
    fmt = in_template[6:0] == 7'b0100011 ? F_S :
          in_template[6:0] == 7'b1100011 ? F_B :
          in_template[6:0] == 7'b1101111 ? F_J :
          in_template[6:0] == 7'b0010111 ? F_U : F_I;
    legal = fmt == F_B ? imm_s >= -64'sd4096 && imm_s <= 64'sd4094 && !in_imm[0] :
            fmt == F_J ? imm_s >= -64'sd1048576 && imm_s <= 64'sd1048574 && !in_imm[0] :
            fmt == F_U ? in_imm[11:0] == 12'd0 && (&in_imm[63:31] || ~|in_imm[63:31]) :
                         imm_s >= -64'sd2048 && imm_s <= 64'sd2047;
  end
  always_comb begin
    s2_load           = !s2_valid_q || out_ready;
    s1_to_s2          = s1_valid_q && s2_load;
    in_ready          = !s1_valid_q || s2_load;
    in_hs             = in_valid && in_ready;
    s1_valid_d        = in_hs || (s1_valid_q && !s2_load);
    s2_valid_d        = s2_load ? s1_valid_q : s2_valid_q;
    s1_tmpl_d         = in_hs ? in_template : s1_tmpl_q;
    s1_imm_d          = in_hs ? in_imm[31:0] : s1_imm_q;
    s1_fmt_d          = in_hs ? fmt : s1_fmt_q;
    s1_err_d          = in_hs ? !legal : s1_err_q;
    out_instruction_d = s1_to_s2 ? word : out_instruction_q;
    out_error_d       = s1_to_s2 ? s1_err_q : out_error_q;
  end
  always_comb begin
    word = s1_fmt_q == F_S ? {s1_imm_q[11:5], s1_tmpl_q[24:12], s1_imm_q[4:0], s1_tmpl_q[6:0]} :
           s1_fmt_q == F_B ? {s1_imm_q[12], s1_imm_q[10:5], s1_tmpl_q[24:12], s1_imm_q[4:1], s1_imm_q[11], s1_tmpl_q[6:0]} :
           s1_fmt_q == F_J ? {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12], s1_tmpl_q[11:0]} :
           s1_fmt_q == F_U ? {s1_imm_q[31:12], s1_tmpl_q[11:0]} :
                             {s1_imm_q[11:0], s1_tmpl_q[19:0]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q        <= 1'b0;
      s2_valid_q        <= 1'b0;
      out_instruction_q <= 32'd0;
      out_error_q       <= 1'b0;
    end else begin
      s1_valid_q        <= s1_valid_d;
      s2_valid_q        <= s2_valid_d;
      out_instruction_q <= out_instruction_d;
      out_error_q       <= out_error_d;
    end
  end
  always_ff @(posedge clk) begin
    s1_tmpl_q <= s1_tmpl_d;
    s1_imm_q  <= s1_imm_d;
    s1_fmt_q  <= s1_fmt_d;
    s1_err_q  <= s1_err_d;
  end
  assign out_valid       = s2_valid_q;
  assign out_instruction = out_instruction_q;
  assign out_error       = out_error_q;
`ifdef ENCODER_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  always_comb begin
    err_count_d = (s2_valid_q && out_ready && out_error_q && !(&err_count_q)) ? err_count_q + 1'b1 : err_count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_q <= '0;
    else        err_count_q <= err_count_d;
  end
  assign err_count = err_count_q;
`endif
endmodule
